// File: rtl/cpu_fetch_seq.sv
// cpu_fetch_seq: multi-cycle fetch/execute sequencer in front of a
// single-cycle datapath. Owns the PC and fetches instruction words over a
// req/ack handshake. Pulses E for one cycle per instruction and commits
// next_pc at the end of that cycle.
// Ports:
//   clk, rst (sync, active-low)
//   next_pc, halt_in         - datapath results, sampled in EXEC only
//   mem_ack, mem_rdata       - fetch response
//   mem_req, mem_addr        - fetch request (word address = pc[31:2])
//   instr, pc                - latched instruction and architectural PC
//   E                        - execute strobe (EXEC state decode)
//   halted, fault            - sticky terminal-state flags
//   instret                  - retired instruction count
// Optional feature: define CPU_FETCH_TIMEOUT_EN to fault a fetch that waits
// TIMEOUT_CYCLES cycles without an ack.
module cpu_fetch_seq #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        halt_in,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        E,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t state, state_n;

  // Low PC bits are forced to zero; the timeout parameter only matters with
  // the macro. Both are folded here so they are intentionally consumed.
  logic unused_bits;
  assign unused_bits = ^{next_pc[1:0], TIMEOUT_CYCLES[0]};

`ifdef CPU_FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_last;

  // True on the wait cycle that brings the count up to the limit.
  assign wait_last = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: zero outside FETCH, so it starts clear on every entry.
  always_ff @(posedge clk) begin
    if (!rst || state != FETCH) begin
      wait_cnt <= '0;
    end else if (!mem_ack) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; an ack always beats the timeout.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = FETCH;
      FETCH: begin
        if (mem_ack) begin
          state_n = EXEC;
`ifdef CPU_FETCH_TIMEOUT_EN
        end else if (wait_last) begin
          state_n = ERR;
`endif
        end
      end
      EXEC:  state_n = halt_in ? HALT : FETCH;
      HALT:  state_n = HALT;
      ERR:   state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  // Datapath registers: instruction latch, PC commit, retire counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= RESET_PC;
      instr   <= '0;
      instret <= '0;
    end else begin
      if (state == FETCH && mem_ack) begin
        instr <= mem_rdata;
      end
      if (state == EXEC) begin
        instret <= instret + 32'd1;
        if (!halt_in) begin
          pc <= {next_pc[31:2], 2'b00};
        end
      end
    end
  end

  // Outputs decoded from the state register only.
  assign E        = (state == EXEC);
  assign mem_req  = (state == FETCH);
  assign mem_addr = pc[31:2];
  assign halted   = (state == HALT);
`ifdef CPU_FETCH_TIMEOUT_EN
  assign fault    = (state == ERR);
`else
  assign fault    = 1'b0;
`endif

endmodule
